axis_frame_gen: RTL and testbench

- Synthesizable AXI4-Stream transmitter that drives protocol-compliant frames onto an axis_if master port.
- Each frame is generated from a command: byte length, seed, TID and TDEST.
- Payload is a deterministic byte-incrementing pattern, so a downstream scoreboard can predict it exactly.
- Active counterpart to the stream protocol checker; used as the stimulus source in simulation and in on-chip loopback tests.

---
 rtl/axis_frame_gen.sv | 111 +++++++++++
 tb/tb_axis_frame_gen.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame generator: turns (length, seed, tid, tdest) commands into
// frames whose payload bytes increment from the seed, one lane per byte.
module axis_frame_gen #(
    parameter int N     = 4,
    parameter int I     = 1,
    parameter int D     = 1,
    parameter int U     = 1,
    parameter int LEN_W = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       cmd_seed,
    input  logic [I-1:0]     cmd_tid,
    input  logic [D-1:0]     cmd_tdest,
    input  logic             throttle,
    output logic             done,
    output logic             busy,
    output logic             tvalid,
    output logic [8*N-1:0]   tdata,
    output logic [N-1:0]     tstrb,
    output logic [N-1:0]     tkeep,
    output logic             tlast,
    output logic [I-1:0]     tid,
    output logic [D-1:0]     tdest,
    output logic [U-1:0]     tuser,
    input  logic             tready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [LEN_W-1:0] left;     // bytes not yet handed over, including the current beat
    logic [7:0]       base;     // value of lane 0 in the current beat
    logic             first;
    logic             hold;     // a beat was presented and not yet taken
    logic [I-1:0]     tid_q;
    logic [D-1:0]     tdest_q;
    logic             is_last;
    logic [N-1:0]     keep;
    logic [8*N-1:0]   data;

    // Handshake: tvalid only rises with throttle low; once up it stays up, with
    // payload and sideband frozen, until the cycle tvalid & tready is seen.
    // Counting down remaining bytes keeps a maximum-length frame from overflowing.
    always_comb begin
        tvalid  = (state == S_SEND) && (hold || !throttle);
        is_last = (left <= LEN_W'(N));
        keep    = '0;
        data    = '0;
        for (int i = 0; i < N; i++) begin
            keep[i] = (left > LEN_W'(i));
            if (keep[i]) data[8*i +: 8] = base + 8'(i);
        end
    end

    assign tdata     = tvalid ? data : '0;
    assign tkeep     = tvalid ? keep : '0;
    assign tstrb     = tkeep;
    assign tlast     = tvalid && is_last;
    assign tid       = tvalid ? tid_q : '0;
    assign tdest     = tvalid ? tdest_q : '0;
    assign tuser     = U'(tvalid && first);
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= S_IDLE;
            left    <= '0;
            base    <= '0;
            first   <= 1'b0;
            hold    <= 1'b0;
            tid_q   <= '0;
            tdest_q <= '0;
        end else begin
            hold <= tvalid && !tready;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        left    <= cmd_len;
                        base    <= cmd_seed;
                        first   <= 1'b1;
                        tid_q   <= cmd_tid;
                        tdest_q <= cmd_tdest;
                        state   <= (cmd_len == '0) ? S_DONE : S_SEND;
                    end
                end
                S_SEND: begin
                    if (tvalid && tready) begin
                        first <= 1'b0;
                        if (is_last) begin
                            state <= S_DONE;
                        end else begin
                            left <= left - LEN_W'(N);
                            base <= base + 8'(N);
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed bench for axis_frame_gen (N=4): frame contents, byte wrap, back-pressure,
// zero length, back-to-back commands, reset mid-frame and maximum length.
module tb_axis_frame_gen;

    localparam int N = 4;
    localparam int I = 1;
    localparam int D = 1;
    localparam int U = 1;
    localparam int LEN_W = 16;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [7:0]       cmd_seed = '0;
    logic [I-1:0]     cmd_tid = '0;
    logic [D-1:0]     cmd_tdest = '0;
    logic             throttle = 1'b0;
    logic             done;
    logic             busy;
    logic             tvalid;
    logic [8*N-1:0]   tdata;
    logic [N-1:0]     tstrb;
    logic [N-1:0]     tkeep;
    logic             tlast;
    logic [I-1:0]     tid;
    logic [D-1:0]     tdest;
    logic [U-1:0]     tuser;
    logic             tready = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    axis_frame_gen #(.N(N), .I(I), .D(D), .U(U), .LEN_W(LEN_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_seed(cmd_seed), .cmd_tid(cmd_tid), .cmd_tdest(cmd_tdest),
        .throttle(throttle), .done(done), .busy(busy),
        .tvalid(tvalid), .tdata(tdata), .tstrb(tstrb), .tkeep(tkeep),
        .tlast(tlast), .tid(tid), .tdest(tdest), .tuser(tuser), .tready(tready)
    );

    always #5 aclk = ~aclk;

    // Presents a command at a falling edge, waits for acceptance, and returns at
    // the falling edge of the cycle after acceptance with cmd_valid dropped.
    task automatic issue_cmd(input logic [LEN_W-1:0] len, input logic [7:0] seed,
                             input logic [I-1:0] id, input logic [D-1:0] dst);
        int waited;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_len = len; cmd_seed = seed; cmd_tid = id; cmd_tdest = dst;
        waited = 0;
        #1;
        while (!cmd_ready && waited < 20) begin
            @(negedge aclk); #1;
            waited++;
        end
        n_checks++;
        if (!cmd_ready) begin
            n_fail++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if ({tvalid, cmd_ready, done, busy, tlast, tuser} !== 6'b010000 || tdata !== '0 || tkeep !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: tvalid=%0b cmd_ready=%0b done=%0b busy=%0b tdata=%h tkeep=%h required 0 1 0 0 0 0",
                     tvalid, cmd_ready, done, busy, tdata, tkeep);
        end
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic test_basic;
        tready = 1'b1; throttle = 1'b0;
        issue_cmd(16'd8, 8'h10, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (tvalid !== 1'b1 || tdata !== 32'h13121110 || tkeep !== 4'hF || tstrb !== 4'hF ||
            tuser !== 1'b1 || tlast !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_beat0: v=%0b d=%h k=%h s=%h u=%0b l=%0b busy=%0b rdy=%0b required 1 13121110 f f 1 0 1 0",
                     tvalid, tdata, tkeep, tstrb, tuser, tlast, busy, cmd_ready);
        end
        @(negedge aclk); #1;
        n_checks++;
        if (tvalid !== 1'b1 || tdata !== 32'h17161514 || tkeep !== 4'hF || tuser !== 1'b0 || tlast !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_beat1: v=%0b d=%h k=%h u=%0b l=%0b required 1 17161514 f 0 1",
                     tvalid, tdata, tkeep, tuser, tlast);
        end
        @(negedge aclk); #1;
        n_checks++;
        if (done !== 1'b1 || tvalid !== 1'b0 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: done=%0b tvalid=%0b cmd_ready=%0b required 1 0 0", done, tvalid, cmd_ready);
        end
        @(negedge aclk); #1;
        n_checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: done=%0b cmd_ready=%0b busy=%0b required 0 1 0", done, cmd_ready, busy);
        end
    endtask

    task automatic test_wrap;
        tready = 1'b1; throttle = 1'b0;
        issue_cmd(16'd5, 8'hFE, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (tvalid !== 1'b1 || tdata !== 32'h0100FFFE || tkeep !== 4'hF || tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_beat0: v=%0b d=%h k=%h l=%0b required 1 0100fffe f 0", tvalid, tdata, tkeep, tlast);
        end
        @(negedge aclk); #1;
        n_checks++;
        if (tvalid !== 1'b1 || tdata !== 32'h00000002 || tkeep !== 4'h1 || tstrb !== 4'h1 || tlast !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_beat1: v=%0b d=%h k=%h s=%h l=%0b required 1 00000002 1 1 1",
                     tvalid, tdata, tkeep, tstrb, tlast);
        end
        @(negedge aclk); #1;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_done: done=%0b required 1", done);
        end
    endtask

    task automatic test_backpressure;
        logic [2:0] thr_pattern;
        thr_pattern = 3'b101;
        tready = 1'b0; throttle = 1'b1;
        issue_cmd(16'd8, 8'h10, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_throttled: tvalid=%0b required 0", tvalid);
        end
        @(negedge aclk);
        throttle = 1'b0; #1;
        n_checks++;
        if (tvalid !== 1'b1 || tdata !== 32'h13121110) begin
            n_fail++;
            $display("FAIL bp_rise: tvalid=%0b tdata=%h required 1 13121110", tvalid, tdata);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            throttle = thr_pattern[c]; #1;
            n_checks++;
            if (tvalid !== 1'b1 || tdata !== 32'h13121110 || tuser !== 1'b1 || tlast !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: v=%0b d=%h u=%0b l=%0b required 1 13121110 1 0",
                         c, tvalid, tdata, tuser, tlast);
            end
        end
        @(negedge aclk);
        tready = 1'b1; throttle = 1'b0; #1;
        n_checks++;
        if (tvalid !== 1'b1 || tdata !== 32'h13121110) begin
            n_fail++;
            $display("FAIL bp_release: tvalid=%0b tdata=%h required 1 13121110", tvalid, tdata);
        end
        @(negedge aclk); #1;
        n_checks++;
        if (tvalid !== 1'b1 || tdata !== 32'h17161514 || tlast !== 1'b1 || tuser !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_beat1: v=%0b d=%h l=%0b u=%0b required 1 17161514 1 0", tvalid, tdata, tlast, tuser);
        end
        @(negedge aclk); #1;
        n_checks++;
        if (done !== 1'b1 || tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_done: done=%0b tvalid=%0b required 1 0", done, tvalid);
        end
    endtask

    task automatic test_zero_len;
        tready = 1'b1; throttle = 1'b0;
        issue_cmd(16'd0, 8'h55, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (done !== 1'b1 || tvalid !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_done: done=%0b tvalid=%0b cmd_ready=%0b busy=%0b required 1 0 0 1",
                     done, tvalid, cmd_ready, busy);
        end
        @(negedge aclk); #1;
        n_checks++;
        if (done !== 1'b0 || tvalid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_idle: done=%0b tvalid=%0b cmd_ready=%0b busy=%0b required 0 0 1 0",
                     done, tvalid, cmd_ready, busy);
        end
    endtask

    task automatic test_back_to_back;
        tready = 1'b1; throttle = 1'b0;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_len = 16'd4; cmd_seed = 8'h00; cmd_tid = 1'b0; cmd_tdest = 1'b0;
        @(negedge aclk);
        cmd_seed = 8'h20; cmd_tid = 1'b1; #1;
        n_checks++;
        if (tvalid !== 1'b1 || tdata !== 32'h03020100 || tlast !== 1'b1 || tid !== 1'b0 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_frame1: v=%0b d=%h l=%0b tid=%0b rdy=%0b required 1 03020100 1 0 0",
                     tvalid, tdata, tlast, tid, cmd_ready);
        end
        @(negedge aclk); #1;
        n_checks++;
        if (done !== 1'b1 || cmd_ready !== 1'b0 || tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done1: done=%0b cmd_ready=%0b tvalid=%0b required 1 0 0", done, cmd_ready, tvalid);
        end
        @(negedge aclk); #1;
        n_checks++;
        if (cmd_ready !== 1'b1 || tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: cmd_ready=%0b tvalid=%0b required 1 0", cmd_ready, tvalid);
        end
        @(negedge aclk);
        cmd_valid = 1'b0; #1;
        n_checks++;
        if (tvalid !== 1'b1 || tdata !== 32'h23222120 || tid !== 1'b1 || tuser !== 1'b1 || tlast !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_frame2: v=%0b d=%h tid=%0b u=%0b l=%0b required 1 23222120 1 1 1",
                     tvalid, tdata, tid, tuser, tlast);
        end
        @(negedge aclk); #1;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done2: done=%0b required 1", done);
        end
    endtask

    task automatic test_reset_mid;
        int done_seen;
        tready = 1'b0; throttle = 1'b0;
        issue_cmd(16'd8, 8'h10, 1'b0, 1'b0);
        tready = 1'b1;
        @(negedge aclk);
        tready = 1'b0; #1;
        n_checks++;
        if (tvalid !== 1'b1 || tdata !== 32'h17161514) begin
            n_fail++;
            $display("FAIL rst_pending: tvalid=%0b tdata=%h required 1 17161514", tvalid, tdata);
        end
        #1 aresetn = 1'b0; #1;
        n_checks++;
        if (tvalid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || tdata !== '0) begin
            n_fail++;
            $display("FAIL rst_drop: tvalid=%0b cmd_ready=%0b busy=%0b tdata=%h required 0 1 0 0",
                     tvalid, cmd_ready, busy, tdata);
        end
        done_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk); #1;
            if (done) done_seen++;
        end
        aresetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk); #1;
            if (done) done_seen++;
        end
        n_checks++;
        if (done_seen !== 0) begin
            n_fail++;
            $display("FAIL rst_no_done: done pulses=%0d required 0", done_seen);
        end
        tready = 1'b1;
        issue_cmd(16'd5, 8'hFE, 1'b1, 1'b1);
        #1;
        n_checks++;
        if (tvalid !== 1'b1 || tdata !== 32'h0100FFFE || tid !== 1'b1 || tdest !== 1'b1 || tuser !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_new_beat0: v=%0b d=%h tid=%0b tdest=%0b u=%0b required 1 0100fffe 1 1 1",
                     tvalid, tdata, tid, tdest, tuser);
        end
        @(negedge aclk); #1;
        n_checks++;
        if (tdata !== 32'h00000002 || tkeep !== 4'h1 || tlast !== 1'b1 || tdest !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_new_beat1: d=%h k=%h l=%0b tdest=%0b required 00000002 1 1 1",
                     tdata, tkeep, tlast, tdest);
        end
        @(negedge aclk); #1;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_new_done: done=%0b required 1", done);
        end
    endtask

    task automatic test_max_len;
        int beats;
        int cycles;
        logic [31:0] last_data;
        logic [3:0]  last_keep;
        tready = 1'b1; throttle = 1'b0;
        issue_cmd(16'hFFFF, 8'h00, 1'b0, 1'b0);
        #1;
        beats = 0; cycles = 0; last_data = '0; last_keep = '0;
        while (cycles < 20000) begin
            if (tvalid) begin
                beats++;
                if (tlast) begin
                    last_data = tdata;
                    last_keep = tkeep;
                    break;
                end
            end
            @(negedge aclk); #1;
            cycles++;
        end
        n_checks++;
        if (beats !== 16384 || last_data !== 32'h00FEFDFC || last_keep !== 4'h7) begin
            n_fail++;
            $display("FAIL max_len: beats=%0d last_data=%h last_keep=%h required 16384 00fefdfc 7",
                     beats, last_data, last_keep);
        end
        @(negedge aclk); #1;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL max_len_done: done=%0b required 1", done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_back_to_back();
        test_reset_mid();
        test_max_len();
        repeat (2) @(negedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
